// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state encoding.
// Command nibble layout is {cs_n, ras_n, cas_n, we_n}.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants init/refresh/write/read engines the command bus, priority refr > wr > rd.
// Grant takes one edge from ARBIT; bus mux is combinational from state; a grant holds until its end flag.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              refr_req,
    input  logic              refr_end,
    input  logic [3:0]        refr_cmd,
    input  logic [ADDR_W-1:0] refr_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_ba,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_ba,
    output logic              refr_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Every grant returns through ARBIT, so back-to-back grants are impossible by construction.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (refr_req)     state_nxt = AREF;
                else if (wr_req)  state_nxt = WRITE;
                else if (rd_req)  state_nxt = READ;
            end
            AREF:    if (refr_end) state_nxt = ARBIT;
            WRITE:   if (wr_end)   state_nxt = ARBIT;
            READ:    if (rd_end)   state_nxt = ARBIT;
            default: state_nxt = INIT;
        endcase
    end

    // Gating with sys_rst_n keeps the engines off the bus the instant reset asserts,
    // without waiting for the state register to be observed.
    always_comb begin
        refr_en    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b00;
        sdram_addr = '0;
        if (sys_rst_n) begin
            case (state)
                INIT: begin
                    sdram_cmd  = init_cmd;
                    sdram_ba   = 2'b11;
                    sdram_addr = init_addr;
                end
                AREF: begin
                    refr_en    = 1'b1;
                    sdram_cmd  = refr_cmd;
                    sdram_ba   = 2'b11;
                    sdram_addr = refr_addr;
                end
                WRITE: begin
                    wr_en      = 1'b1;
                    sdram_cmd  = wr_cmd;
                    sdram_ba   = wr_ba;
                    sdram_addr = wr_addr;
                end
                READ: begin
                    rd_en      = 1'b1;
                    sdram_cmd  = rd_cmd;
                    sdram_ba   = rd_ba;
                    sdram_addr = rd_addr;
                end
                default: ;
            endcase
        end
    end

    assign sdram_cke = sys_rst_n;

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, SDRAM row/column address width.
REQ-002 SHALL have port sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports init_end  in  1, init_cmd  in  4, init_addr  in  ADDR_W: power-up init done flag, init command, init address.
REQ-005 SHALL have ports refr_req  in  1, refr_end  in  1, refr_cmd  in  4, refr_addr  in  ADDR_W: auto-refresh request, done flag, command, address.
REQ-006 SHALL have ports wr_req  in  1, wr_end  in  1, wr_cmd  in  4, wr_addr  in  ADDR_W, wr_ba  in  2: write request, done flag, command, address, bank.
REQ-007 SHALL have ports rd_req  in  1, rd_end  in  1, rd_cmd  in  4, rd_addr  in  ADDR_W, rd_ba  in  2: read request, done flag, command, address, bank.
REQ-008 SHALL have ports refr_en  out  1, wr_en  out  1, rd_en  out  1: grants to the refresh, write and read engines.
REQ-009 SHALL have ports sdram_cke  out  1, sdram_cmd  out  4 ({cs_n,ras_n,cas_n,we_n}), sdram_ba  out  2, sdram_addr  out  ADDR_W: SDRAM command bus.

Function
REQ-010 SHALL implement FSM with states INIT, ARBIT, AREF, WRITE, READ.
REQ-011 INIT SHALL move to ARBIT on the first edge with init_end=1; init_end deasserting later SHALL be ignored.
REQ-012 ARBIT SHALL select on a single edge with fixed priority refr_req > wr_req > rd_req -> AREF / WRITE / READ; with no request SHALL stay in ARBIT.
REQ-013 AREF/WRITE/READ SHALL return to ARBIT on the first edge with refr_end / wr_end / rd_end =1 respectively; other requests SHALL NOT preempt an active grant.
REQ-014 ARBIT SHALL last at least one cycle between any two grants; no back-to-back grant without an intervening ARBIT cycle.
REQ-015 refr_en, wr_en and rd_en SHALL be decoded from state only: 1 exactly while in AREF, WRITE and READ respectively; at most one SHALL be 1 in any cycle.
REQ-016 Command mux SHALL be combinational from state, with zero added latency.
REQ-016a In INIT: sdram_cmd=init_cmd, sdram_addr=init_addr, sdram_ba=2'b11.
REQ-016b In AREF: sdram_cmd=refr_cmd, sdram_addr=refr_addr, sdram_ba=2'b11.
REQ-016c In WRITE: sdram_cmd=wr_cmd, sdram_addr=wr_addr, sdram_ba=wr_ba.
REQ-016d In READ: sdram_cmd=rd_cmd, sdram_addr=rd_addr, sdram_ba=rd_ba.
REQ-017 ARBIT SHALL drive sdram_cmd=NOP (4'b0111), sdram_addr=0, sdram_ba=2'b00.
REQ-018 sdram_cke SHALL be 1 whenever sys_rst_n=1.
REQ-019 A request arriving together with the active engine's end flag SHALL be served only after one ARBIT cycle, per REQ-012 priority.
REQ-020 An unreachable state encoding SHALL recover to INIT on the next edge.

Reset
REQ-021 sys_rst_n=0 SHALL immediately force state=INIT, refr_en=wr_en=rd_en=0, sdram_cke=0, sdram_cmd=NOP, sdram_addr=0, sdram_ba=2'b00; asserting it mid-grant SHALL abort the grant with no further engine command on the bus.

Structure
REQ-022 Command encodings (NOP 0111, PRE 0010, AREF 0001, ACT 0011, WR 0100, RD 0101, MRS 0000) and the state encoding SHALL live in shared package sdram_pkg.
REQ-023 Single module, no sub-module; FSM register plus combinational decode/mux only.

Verification
REQ-024 Reset released, init_end=0 for 20 cycles -> sdram_cmd tracks init_cmd, all en=0; init_end=1 -> ARBIT next edge, sdram_cmd=NOP.
REQ-025 refr_req, wr_req, rd_req all rise together in ARBIT -> refr_en=1 next edge; after refr_end, one NOP cycle, then wr_en=1; after wr_end, one NOP cycle, then rd_en=1.
REQ-026 In WRITE, refr_req rises -> wr_en stays 1 until wr_end; then AREF granted after one ARBIT cycle.
REQ-027 In WRITE, wr_cmd=0100, wr_addr=0x155, wr_ba=2'b10 -> same cycle sdram_cmd=0100, sdram_addr=0x155, sdram_ba=2'b10.
REQ-028 sys_rst_n pulsed low while in READ -> rd_en=0 and sdram_cmd=NOP immediately; state returns to INIT.
REQ-029 Every cycle of every test -> at most one enable high, checked by assertion.
